// File: rtl/hdr_pkg.sv
// Shared constants and FSM state type for the HDR weight sequencer.
package hdr_pkg;

  localparam int HDR_PIX_W        = 5;
  localparam int HDR_W_W          = 8;
  localparam int HDR_FRAME_W      = 320;
  localparam int HDR_FRAME_H      = 240;
  localparam int HDR_FRAME_PIXELS = HDR_FRAME_W * HDR_FRAME_H;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WEIGH   = 2'd2,
    OUTPUT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/hdr_px_capture.sv
// Single exposure channel: one capture register plus a "have pixel" flag.
module hdr_px_capture #(
  parameter int PIX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             valid,
  input  logic [PIX_W-1:0] data,
  output logic             ready,
  output logic             fire,
  output logic             flag,
  output logic [PIX_W-1:0] pix
);

  logic             flag_reg;
  logic [PIX_W-1:0] pix_reg;

  assign ready = en & ~flag_reg;
  assign fire  = valid & ready;
  assign flag  = flag_reg;
  assign pix   = pix_reg;

  // clr wins over a same-cycle capture so an aborted pixel is never kept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_reg <= 1'b0;
      pix_reg  <= '0;
    end else if (clr) begin
      flag_reg <= 1'b0;
    end else if (fire) begin
      flag_reg <= 1'b1;
      pix_reg  <= data;
    end
  end

endmodule

// File: rtl/hdr_weight_seq.sv
// Gathers one pixel per exposure, strobes the weight unit and hands the result downstream.
// Optional stall counter enabled by defining HDR_SEQ_STALL_CNT_EN.
module hdr_weight_seq
  import hdr_pkg::*;
#(
  parameter int PIX_W        = HDR_PIX_W,
  parameter int W_W          = HDR_W_W,
  parameter int FRAME_PIXELS = HDR_FRAME_PIXELS,
  parameter int CNT_W        = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_go,
  input  logic             frame_abort,
  input  logic             px_high_valid,
  input  logic             px_mid_valid,
  input  logic             px_low_valid,
  output logic             px_high_ready,
  output logic             px_mid_ready,
  output logic             px_low_ready,
  input  logic [PIX_W-1:0] px_high,
  input  logic [PIX_W-1:0] px_mid,
  input  logic [PIX_W-1:0] px_low,
  output logic             wu_start,
  output logic [PIX_W-1:0] wu_pixel_high,
  output logic [PIX_W-1:0] wu_pixel_mid,
  output logic [PIX_W-1:0] wu_pixel_low,
  input  logic [W_W-1:0]   wu_w_high,
  input  logic [W_W-1:0]   wu_w_mid,
  input  logic [W_W-1:0]   wu_w_low,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix_high,
  output logic [PIX_W-1:0] out_pix_mid,
  output logic [PIX_W-1:0] out_pix_low,
  output logic [W_W-1:0]   out_w_high,
  output logic [W_W-1:0]   out_w_mid,
  output logic [W_W-1:0]   out_w_low,
  output logic [W_W+1:0]   out_wsum,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      stall_cycles
);

  seq_state_e state_reg, state_next;

  logic [CNT_W-1:0] count_reg;
  logic             frame_done_reg;
  logic [PIX_W-1:0] wu_pix_reg [3];

  logic             in_collect;
  logic             go_accept;
  logic             accept;
  logic             last_pix;
  logic             all_set;
  logic             clr;

  // channel index: 0 = high, 1 = mid, 2 = low
  logic [2:0]       valid_v, ready_v, fire_v, flag_v;
  logic [PIX_W-1:0] data_v [3];
  logic [PIX_W-1:0] pix_v  [3];
  logic [PIX_W-1:0] cap_v  [3];

  assign valid_v   = {px_low_valid, px_mid_valid, px_high_valid};
  assign data_v[0] = px_high;
  assign data_v[1] = px_mid;
  assign data_v[2] = px_low;

  assign go_accept = (state_reg == IDLE) & frame_go & ~frame_abort;
  assign accept    = (state_reg == OUTPUT) & out_ready;
  assign last_pix  = (count_reg == CNT_W'(FRAME_PIXELS - 1));
  assign all_set   = &(flag_v | fire_v);
  assign clr       = frame_abort | accept | go_accept;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      hdr_px_capture #(.PIX_W(PIX_W)) u_cap (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_collect),
        .clr   (clr),
        .valid (valid_v[gi]),
        .data  (data_v[gi]),
        .ready (ready_v[gi]),
        .fire  (fire_v[gi]),
        .flag  (flag_v[gi]),
        .pix   (pix_v[gi])
      );

      // includes a same-cycle capture so WEIGH sees the complete triple
      assign cap_v[gi] = fire_v[gi] ? data_v[gi] : pix_v[gi];

      // loaded only on entry to WEIGH, so the weight unit inputs stay put otherwise
      always_ff @(posedge clk) begin
        if (!rst_n)
          wu_pix_reg[gi] <= '0;
        else if (in_collect && all_set && !frame_abort)
          wu_pix_reg[gi] <= cap_v[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (frame_abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (frame_go) state_next = COLLECT;
        COLLECT: if (all_set) state_next = WEIGH;
        WEIGH:   state_next = OUTPUT;
        OUTPUT:  if (out_ready) state_next = last_pix ? IDLE : COLLECT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_collect = 1'b0;
    wu_start   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE:    busy = 1'b0;
      COLLECT: in_collect = 1'b1;
      WEIGH:   wu_start = 1'b1;
      OUTPUT:  out_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= accept & last_pix & ~frame_abort;
      if (frame_abort || go_accept)
        count_reg <= '0;
      else if (accept)
        count_reg <= last_pix ? '0 : count_reg + 1'b1;
    end
  end

  assign px_high_ready = ready_v[0];
  assign px_mid_ready  = ready_v[1];
  assign px_low_ready  = ready_v[2];

  assign wu_pixel_high = wu_pix_reg[0];
  assign wu_pixel_mid  = wu_pix_reg[1];
  assign wu_pixel_low  = wu_pix_reg[2];

  assign out_pix_high = pix_v[0];
  assign out_pix_mid  = pix_v[1];
  assign out_pix_low  = pix_v[2];

  assign out_w_high = out_valid ? wu_w_high : '0;
  assign out_w_mid  = out_valid ? wu_w_mid  : '0;
  assign out_w_low  = out_valid ? wu_w_low  : '0;
  assign out_wsum   = {2'b00, out_w_high} + {2'b00, out_w_mid} + {2'b00, out_w_low};
  assign out_last   = out_valid & last_pix;
  assign frame_done = frame_done_reg;

`ifdef HDR_SEQ_STALL_CNT_EN
  logic [15:0] stall_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_reg <= '0;
    else if (go_accept)
      stall_reg <= '0;
    else if (out_valid && !out_ready && stall_reg != 16'hFFFF)
      stall_reg <= stall_reg + 16'd1;
  end

  assign stall_cycles = stall_reg;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hdr_weight_seq.sv
// Directed bench for hdr_weight_seq with a behavioural 5-bit triangle-weight unit.
`timescale 1ns/1ps
module tb_hdr_weight_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_go, frame_abort;
  logic        px_high_valid, px_mid_valid, px_low_valid;
  logic        px_high_ready, px_mid_ready, px_low_ready;
  logic [4:0]  px_high, px_mid, px_low;
  logic        wu_start;
  logic [4:0]  wu_pixel_high, wu_pixel_mid, wu_pixel_low;
  logic [7:0]  wu_w_high, wu_w_mid, wu_w_low;
  logic        out_valid, out_ready;
  logic [4:0]  out_pix_high, out_pix_mid, out_pix_low;
  logic [7:0]  out_w_high, out_w_mid, out_w_low;
  logic [9:0]  out_wsum;
  logic        out_last, busy, frame_done;
  logic [15:0] stall_cycles;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  hdr_weight_seq #(.PIX_W(5), .W_W(8), .FRAME_PIXELS(4), .CNT_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .frame_go(frame_go), .frame_abort(frame_abort),
    .px_high_valid(px_high_valid), .px_mid_valid(px_mid_valid), .px_low_valid(px_low_valid),
    .px_high_ready(px_high_ready), .px_mid_ready(px_mid_ready), .px_low_ready(px_low_ready),
    .px_high(px_high), .px_mid(px_mid), .px_low(px_low),
    .wu_start(wu_start),
    .wu_pixel_high(wu_pixel_high), .wu_pixel_mid(wu_pixel_mid), .wu_pixel_low(wu_pixel_low),
    .wu_w_high(wu_w_high), .wu_w_mid(wu_w_mid), .wu_w_low(wu_w_low),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pix_high(out_pix_high), .out_pix_mid(out_pix_mid), .out_pix_low(out_pix_low),
    .out_w_high(out_w_high), .out_w_mid(out_w_mid), .out_w_low(out_w_low),
    .out_wsum(out_wsum), .out_last(out_last), .busy(busy), .frame_done(frame_done),
    .stall_cycles(stall_cycles)
  );

  // Weight unit stand-in: rises 1..16 over 0..15, falls 16..1 over 16..31; registered on start.
  function automatic logic [7:0] tri_weight(input logic [4:0] z);
    return (z <= 5'd15) ? ({3'b000, z} + 8'd1) : (8'd32 - {3'b000, z});
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      wu_w_high <= '0;
      wu_w_mid  <= '0;
      wu_w_low  <= '0;
    end else if (wu_start) begin
      wu_w_high <= tri_weight(wu_pixel_high);
      wu_w_mid  <= tri_weight(wu_pixel_mid);
      wu_w_low  <= tri_weight(wu_pixel_low);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
  endtask

  task automatic chk_ready(input string tag, input logic [2:0] exp_v);
    chk(tag, {29'd0, px_high_ready, px_mid_ready, px_low_ready}, {29'd0, exp_v});
  endtask

  // Presents all three pixels in one cycle and advances past the capture edge.
  task automatic drive_triple(input logic [4:0] h, input logic [4:0] m, input logic [4:0] l);
    px_high = h; px_mid = m; px_low = l;
    px_high_valid = 1'b1; px_mid_valid = 1'b1; px_low_valid = 1'b1;
    tick();
    px_high_valid = 1'b0; px_mid_valid = 1'b0; px_low_valid = 1'b0;
  endtask

  task automatic chk_weigh(input string tag, input logic [4:0] h, input logic [4:0] m,
                           input logic [4:0] l);
    chk({tag, "_wu_start"}, 32'(wu_start), 32'd1);
    chk({tag, "_wu_hi"}, 32'(wu_pixel_high), 32'(h));
    chk({tag, "_wu_mid"}, 32'(wu_pixel_mid), 32'(m));
    chk({tag, "_wu_lo"}, 32'(wu_pixel_low), 32'(l));
    chk({tag, "_valid_in_weigh"}, 32'(out_valid), 32'd0);
    chk_ready({tag, "_ready_in_weigh"}, 3'b000);
  endtask

  task automatic chk_out(input string tag, input logic [4:0] h, input logic [4:0] m,
                         input logic [4:0] l, input logic [7:0] wh, input logic [7:0] wm,
                         input logic [7:0] wl, input logic [9:0] sum, input logic last);
    $display("txn %s: pix %0d/%0d/%0d w %0d/%0d/%0d sum %0d last %0d", tag,
             out_pix_high, out_pix_mid, out_pix_low, out_w_high, out_w_mid, out_w_low,
             out_wsum, out_last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pix_hi"}, 32'(out_pix_high), 32'(h));
    chk({tag, "_pix_mid"}, 32'(out_pix_mid), 32'(m));
    chk({tag, "_pix_lo"}, 32'(out_pix_low), 32'(l));
    chk({tag, "_w_hi"}, 32'(out_w_high), 32'(wh));
    chk({tag, "_w_mid"}, 32'(out_w_mid), 32'(wm));
    chk({tag, "_w_lo"}, 32'(out_w_low), 32'(wl));
    chk({tag, "_wsum"}, 32'(out_wsum), 32'(sum));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    chk_ready({tag, "_ready_in_out"}, 3'b000);
  endtask

  initial begin
    rst_n = 1'b0; frame_go = 1'b0; frame_abort = 1'b0; out_ready = 1'b1;
    px_high_valid = 1'b0; px_mid_valid = 1'b0; px_low_valid = 1'b0;
    px_high = '0; px_mid = '0; px_low = '0;
    repeat (3) tick();

    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_start", 32'(wu_start), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk_ready("rst_ready", 3'b000);
    rst_n = 1'b1;
    tick();
    chk_ready("idle_ready", 3'b000);

    // pixel 1: simultaneous arrival, then 7 cycles of backpressure
    frame_go = 1'b1; tick(); frame_go = 1'b0;
    chk("go_busy", 32'(busy), 32'd1);
    chk_ready("collect_ready", 3'b111);
    out_ready = 1'b0;
    drive_triple(5'd3, 5'd16, 5'd31);
    chk_weigh("p1", 5'd3, 5'd16, 5'd31);
    tick();
    chk("p1_start_once", 32'(wu_start), 32'd0);
    chk_out("p1", 5'd3, 5'd16, 5'd31, 8'd4, 8'd16, 8'd1, 10'd21, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_out("p1_hold", 5'd3, 5'd16, 5'd31, 8'd4, 8'd16, 8'd1, 10'd21, 1'b0);
    end
`ifdef HDR_SEQ_STALL_CNT_EN
    chk("stall_7", 32'(stall_cycles), 32'd7);
`else
    chk("stall_tied", 32'(stall_cycles), 32'd0);
`endif
    out_ready = 1'b1;
    tick();
    chk("p1_accepted", 32'(out_valid), 32'd0);
    chk_ready("p1_ready_back", 3'b111);

    // pixel 2: skewed arrivals low@0, high@5, mid@9
    px_low = 5'd0; px_low_valid = 1'b1; tick(); px_low_valid = 1'b0;
    chk_ready("skew_low", 3'b110);
    repeat (4) tick();
    chk_ready("skew_wait", 3'b110);
    px_high = 5'd10; px_high_valid = 1'b1; tick(); px_high_valid = 1'b0;
    chk_ready("skew_high", 3'b010);
    repeat (3) tick();
    chk("skew_no_start", 32'(wu_start), 32'd0);
    px_mid = 5'd20; px_mid_valid = 1'b1; tick(); px_mid_valid = 1'b0;
    chk_weigh("p2", 5'd10, 5'd20, 5'd0);
    tick();
    chk_out("p2", 5'd10, 5'd20, 5'd0, 8'd11, 8'd12, 8'd1, 10'd24, 1'b0);
    tick();
    chk("p2_no_done", 32'(frame_done), 32'd0);

    // pixels 3 and 4 (last)
    drive_triple(5'd15, 5'd17, 5'd5);
    tick();
    chk_out("p3", 5'd15, 5'd17, 5'd5, 8'd16, 8'd15, 8'd6, 10'd37, 1'b0);
    tick();
    drive_triple(5'd0, 5'd31, 5'd16);
    tick();
    chk_out("p4", 5'd0, 5'd31, 5'd16, 8'd1, 8'd1, 8'd16, 10'd18, 1'b1);
    tick();
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk_ready("end_ready", 3'b000);
    px_high_valid = 1'b1; px_mid_valid = 1'b1; px_low_valid = 1'b1;
    tick();
    chk("frame_done_once", 32'(frame_done), 32'd0);
    chk_ready("idle_ignores", 3'b000);
    chk("idle_no_start", 32'(wu_start), 32'd0);
    px_high_valid = 1'b0; px_mid_valid = 1'b0; px_low_valid = 1'b0;

    // abort during OUTPUT of the second pixel
    frame_go = 1'b1; tick(); frame_go = 1'b0;
    drive_triple(5'd1, 5'd2, 5'd3);
    tick();
    chk_out("a1", 5'd1, 5'd2, 5'd3, 8'd2, 8'd3, 8'd4, 10'd9, 1'b0);
    tick();
    out_ready = 1'b0;
    drive_triple(5'd4, 5'd5, 5'd6);
    tick();
    chk("a2_valid", 32'(out_valid), 32'd1);
    frame_abort = 1'b1;
    tick();
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(frame_done), 32'd0);
    frame_abort = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("abort_no_done2", 32'(frame_done), 32'd0);
    chk_ready("abort_ready", 3'b000);

    // restart: count back at 0, last only on the 4th pixel
    frame_go = 1'b1; tick(); frame_go = 1'b0;
    chk("restart_stall_clr", 32'(stall_cycles), 32'd0);
    drive_triple(5'd7, 5'd8, 5'd9);
    tick();
    chk_out("r1", 5'd7, 5'd8, 5'd9, 8'd8, 8'd9, 8'd10, 10'd27, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      drive_triple(5'(k), 5'(k), 5'(k));
      tick();
      chk_out($sformatf("r%0d", k + 1), 5'(k), 5'(k), 5'(k), 8'(k + 1), 8'(k + 1),
              8'(k + 1), 10'(3 * k + 3), (k == 3));
      tick();
    end
    chk("restart_done", 32'(frame_done), 32'd1);

    // reset while in WEIGH
    frame_go = 1'b1; tick(); frame_go = 1'b0;
    drive_triple(5'd2, 5'd2, 5'd2);
    chk("pre_rst_start", 32'(wu_start), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_start", 32'(wu_start), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wu_pix", 32'(wu_pixel_high), 32'd0);
    chk("mid_rst_out_pix", 32'(out_pix_mid), 32'd0);
    chk("mid_rst_wsum", 32'(out_wsum), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    chk_ready("mid_rst_ready", 3'b000);
    rst_n = 1'b1;
    px_high_valid = 1'b1; px_mid_valid = 1'b1; px_low_valid = 1'b1;
    repeat (2) tick();
    chk_ready("post_rst_ready", 3'b000);
    chk("post_rst_busy", 32'(busy), 32'd0);
    px_high_valid = 1'b0; px_mid_valid = 1'b0; px_low_valid = 1'b0;
    frame_go = 1'b1; tick(); frame_go = 1'b0;
    chk_ready("post_rst_go", 3'b111);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hdr_weight_seq.md
Name: hdr_weight_seq

Overview:
Sequencer that feeds the 5-bit HDR triangle-weight unit. It gathers one pixel from each of the three exposure streams (high, mid, low), which arrive independently under valid/ready. It pulses the weight unit's start, then presents the pixel triple, its three weights and their sum to the downstream merge stage under valid/ready. It counts pixels per frame, flags the last pixel, and signals frame completion.

Parameters:
PIX_W, 5, pixel width per exposure.
W_W, 8, weight width; must match the weight unit outputs.
FRAME_PIXELS, 76800, pixels per frame (320x240).
CNT_W, 17, pixel counter width; must satisfy 2**CNT_W >= FRAME_PIXELS.

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous reset, active-low.
frame_go  in  1  pulse; arms the block for one frame.
frame_abort  in  1  level; forces return to IDLE.
px_high_valid / px_mid_valid / px_low_valid  in  1 each  exposure pixel valid.
px_high_ready / px_mid_ready / px_low_ready  out  1 each  exposure pixel ready.
px_high / px_mid / px_low  in  PIX_W each  exposure pixel data.
wu_start  out  1  start strobe to the weight unit.
wu_pixel_high / wu_pixel_mid / wu_pixel_low  out  PIX_W each  pixels to the weight unit.
wu_w_high / wu_w_mid / wu_w_low  in  W_W each  registered weights from the weight unit.
out_valid  out  1  result valid.
out_ready  in  1  downstream ready.
out_pix_high / out_pix_mid / out_pix_low  out  PIX_W each  captured pixels.
out_w_high / out_w_mid / out_w_low  out  W_W each  weights.
out_wsum  out  W_W+2  sum of the three weights.
out_last  out  1  marks the final pixel of the frame.
busy  out  1  high when not in IDLE.
frame_done  out  1  one-cycle pulse when the frame completes.
stall_cycles  out  16  performance counter (see Optional Feature).

Behaviour:
- Reset: FSM to IDLE; capture flags, pixel count, wu_start, out_valid, out_last, frame_done, busy and stall_cycles all 0. Capture registers go to 0.
- FSM states are IDLE, COLLECT, WEIGH and OUTPUT.
- IDLE:
  - All px_*_ready are 0.
  - frame_go moves to COLLECT and clears the pixel count.
- COLLECT:
  - Each channel has a capture register and a flag.
  - px_x_ready = ~flag_x.
  - On valid & ready the pixel is stored and flag_x is set.
  - When all three flags are set, or become set this cycle, the FSM moves to WEIGH on the next edge.
  - Channels are captured independently; arrival order does not matter.
- WEIGH:
  - wu_start = 1 for exactly one cycle; wu_pixel_* = captured pixels.
  - Next state is OUTPUT. The weight unit registers the weights at the end of this cycle.
- OUTPUT:
  - out_valid = 1.
  - out_w_* = wu_w_*; out_wsum = zero-extended sum with no overflow (max 3*16 = 48).
  - out_last = 1 when count == FRAME_PIXELS-1.
  - Outputs hold stable while out_ready = 0.
  - On out_ready: flags clear and count increments.
  - If out_last was set: frame_done pulses on the next cycle, count resets and the FSM goes to IDLE. Otherwise it returns to COLLECT.
- Latency: at best 3 cycles from the final capture to out_valid. Peak throughput is 1 pixel per 3 cycles. wu_pixel_* remain constant outside WEIGH.
- frame_abort has priority over every transition:
  - The FSM goes to IDLE.
  - Flags and count clear.
  - out_valid drops on the next cycle; a partially consumed output is lost.
  - frame_done does not pulse.
- frame_go outside IDLE is ignored.
- Reset mid-frame behaves like an abort and also clears all registers.
- Count wrap: the count never exceeds FRAME_PIXELS-1.

Optional Feature:
HDR_SEQ_STALL_CNT_EN
- Defined: stall_cycles counts cycles where out_valid & ~out_ready. It saturates at 0xFFFF and clears on an accepted frame_go.
- Undefined: the stall_cycles port is still present but tied to 0, and no counter logic is built.

Decomposition:
- Shared package hdr_pkg holds:
  - PIX_W and W_W constants;
  - the FSM state enum (IDLE, COLLECT, WEIGH, OUTPUT);
  - the frame geometry constants (width 320, height 240, FRAME_PIXELS).
- One natural sub-module, hdr_px_capture: a single-channel capture register and flag, instantiated three times. The weight unit itself is instantiated outside this block.

Test Plan:
- Bench configuration: weight unit instantiated alongside the block; FRAME_PIXELS = 4.
- Pixel triple: frame_go, then high=3, mid=16, low=31, all valid in the same cycle -> wu_start pulses once; out_w = 4/16/1, out_wsum = 21; out_valid appears 3 cycles after capture.
- Skewed arrivals: low at cycle 0, high at cycle 5, mid at cycle 9 -> each ready drops after its own capture; WEIGH begins one cycle after the mid capture; data is correct.
- Backpressure: out_ready held at 0 for 7 cycles -> outputs stable, all px ready stay 0; with the macro defined, stall_cycles = 7.
- Full frame: 4 triples accepted -> out_last set only on the 4th; frame_done pulses once; FSM returns to IDLE with busy = 0; px ready stays 0 until the next frame_go.
- Abort: frame_abort asserted in OUTPUT on the 2nd pixel -> out_valid = 0 on the next cycle, no frame_done; a new frame_go restarts the count at 0 and the first output has out_last = 0.
- Reset: rst_n low in WEIGH -> all outputs 0; the block accepts nothing until frame_go.
